// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one input bit per clock.
// Start/busy/valid handshake, optional sign-magnitude input, sticky overflow flag.
module bcd_convert_seq #(
   parameter int unsigned BIN_W  = 32,
   parameter int unsigned DIGITS = 10,
   parameter bit          SIGNED = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  neg,
   output logic                  ovf
);

   localparam int unsigned BcdW = 4 * DIGITS;
   localparam int unsigned CntW = $clog2(BIN_W);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e            state_q, state_d;
   logic [BIN_W-1:0]  sr_q, sr_d;
   logic [BcdW-1:0]   acc_q, acc_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              sign_q, sign_d;
   logic              ovf_acc_q, ovf_acc_d;
   logic [BcdW-1:0]   bcd_q, bcd_d;
   logic              neg_q, neg_d;
   logic              ovf_q, ovf_d;
   logic              valid_q, valid_d;

   logic [BcdW-1:0]   adj;
   logic [BIN_W-1:0]  mag;
   logic              in_neg;

   always_comb begin
      adj = acc_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
   end

   // Two's complement of the most negative value wraps to itself, read as unsigned.
   assign in_neg = SIGNED && bin[BIN_W-1];
   assign mag    = in_neg ? (~bin + BIN_W'(1)) : bin;

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sign_d    = sign_q;
      ovf_acc_d = ovf_acc_q;
      bcd_d     = bcd_q;
      neg_d     = neg_q;
      ovf_d     = ovf_q;
      valid_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               sr_d      = mag;
               sign_d    = in_neg;
               acc_d     = '0;
               ovf_acc_d = 1'b0;
               cnt_d     = CntW'(BIN_W - 1);
               state_d   = StShift;
            end
         end
         StShift: begin
            acc_d     = {adj[BcdW-2:0], sr_q[BIN_W-1]};
            sr_d      = {sr_q[BIN_W-2:0], 1'b0};
            ovf_acc_d = ovf_acc_q | adj[BcdW-1];
            cnt_d     = cnt_q - CntW'(1);
            if (cnt_q == '0) begin
               bcd_d   = acc_d;
               neg_d   = sign_q;
               ovf_d   = ovf_acc_d;
               valid_d = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         sr_q      <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         sign_q    <= 1'b0;
         ovf_acc_q <= 1'b0;
         bcd_q     <= '0;
         neg_q     <= 1'b0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         sign_q    <= sign_d;
         ovf_acc_q <= ovf_acc_d;
         bcd_q     <= bcd_d;
         neg_q     <= neg_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
      end
   end

   assign busy  = (state_q == StShift);
   assign valid = valid_q;
   assign bcd   = bcd_q;
   assign neg   = neg_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Directed bench for bcd_convert_seq: several parameterisations share clock and reset,
// each converted value is checked against hand-computed BCD, sign, overflow and latency.
module tb_bcd_convert_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  start_v = '0;
   logic [31:0] bin_v [6];
   logic [5:0]  busy_v, valid_v, neg_v, ovf_v;
   logic [39:0] bcd0, bcd2;
   logic [15:0] bcd1;
   logic [11:0] bcd3;
   logic [7:0]  bcd4;
   logic [19:0] bcd5;

   int          sel = 0;
   logic        o_busy, o_valid, o_neg, o_ovf;
   logic [39:0] o_bcd;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // Default: 32-bit unsigned, 10 digits
   bcd_convert_seq u_dut0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .bin(bin_v[0]), .busy(busy_v[0]),
      .valid(valid_v[0]), .bcd(bcd0), .neg(neg_v[0]), .ovf(ovf_v[0]));
   bcd_convert_seq #(.BIN_W(32), .DIGITS(4), .SIGNED(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .bin(bin_v[1]), .busy(busy_v[1]),
      .valid(valid_v[1]), .bcd(bcd1), .neg(neg_v[1]), .ovf(ovf_v[1]));
   bcd_convert_seq #(.BIN_W(32), .DIGITS(10), .SIGNED(1'b1)) u_dut2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .bin(bin_v[2]), .busy(busy_v[2]),
      .valid(valid_v[2]), .bcd(bcd2), .neg(neg_v[2]), .ovf(ovf_v[2]));
   bcd_convert_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b1)) u_dut3 (
      .clk(clk), .rst(rst), .start(start_v[3]), .bin(bin_v[3][7:0]), .busy(busy_v[3]),
      .valid(valid_v[3]), .bcd(bcd3), .neg(neg_v[3]), .ovf(ovf_v[3]));
   bcd_convert_seq #(.BIN_W(8), .DIGITS(2), .SIGNED(1'b0)) u_dut4 (
      .clk(clk), .rst(rst), .start(start_v[4]), .bin(bin_v[4][7:0]), .busy(busy_v[4]),
      .valid(valid_v[4]), .bcd(bcd4), .neg(neg_v[4]), .ovf(ovf_v[4]));
   bcd_convert_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b0)) u_dut5 (
      .clk(clk), .rst(rst), .start(start_v[5]), .bin(bin_v[5][15:0]), .busy(busy_v[5]),
      .valid(valid_v[5]), .bcd(bcd5), .neg(neg_v[5]), .ovf(ovf_v[5]));

   always_comb begin
      o_busy  = busy_v[sel];
      o_valid = valid_v[sel];
      o_neg   = neg_v[sel];
      o_ovf   = ovf_v[sel];
      case (sel)
         0:       o_bcd = bcd0;
         1:       o_bcd = 40'(bcd1);
         2:       o_bcd = bcd2;
         3:       o_bcd = 40'(bcd3);
         4:       o_bcd = 40'(bcd4);
         default: o_bcd = 40'(bcd5);
      endcase
   end

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Caller sits at a negedge; returns at the negedge after the accepting edge.
   task automatic launch(input int which, input logic [31:0] b);
      sel = which;
      start_v[which] = 1'b1;
      bin_v[which]   = b;
      @(negedge clk);
      start_v[which] = 1'b0;
   endtask

   // n0 = cycles already elapsed since acceptance; returns at the negedge where valid is high.
   task automatic wait_result(input int n0, input int bin_w, input logic [39:0] eb,
                              input logic en, input logic eo, input string tag);
      int n = n0;
      chk({tag, "_busy"}, 40'(o_busy), 40'd1);
      while (!o_valid && n < bin_w + 4) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, 40'(n), 40'(bin_w));
      chk({tag, "_idle"}, 40'(o_busy), 40'd0);
      chk({tag, "_bcd"}, o_bcd, eb);
      chk({tag, "_neg"}, 40'(o_neg), 40'(en));
      chk({tag, "_ovf"}, 40'(o_ovf), 40'(eo));
   endtask

   initial begin
      for (int i = 0; i < 6; i++) bin_v[i] = '0;
      repeat (3) @(negedge clk);
      sel = 0;
      chk("rst_bcd", o_bcd, 40'h0);
      chk("rst_busy", 40'(o_busy), 40'd0);
      chk("rst_valid", 40'(o_valid), 40'd0);
      chk("rst_ovf", 40'(o_ovf), 40'd0);
      rst = 1'b0;
      @(negedge clk);

      // Unsigned 32-bit, 10 digits
      launch(0, 32'd0);
      wait_result(0, 32, 40'h0, 1'b0, 1'b0, "zero");
      @(negedge clk);
      chk("valid_pulse", 40'(o_valid), 40'd0);
      chk("hold_bcd", o_bcd, 40'h0);

      launch(0, 32'hFFFF_FFFF);
      repeat (5) @(negedge clk);
      start_v[0] = 1'b1;
      bin_v[0]   = 32'd99;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_result(6, 32, 40'h42_9496_7295, 1'b0, 1'b0, "max");
      launch(0, 32'd99);
      chk("hold_at_accept", o_bcd, 40'h42_9496_7295);
      wait_result(0, 32, 40'h99, 1'b0, 1'b0, "b2b99");

      // 4 digits: overflow keeps the low digits
      @(negedge clk);
      launch(1, 32'd12345);
      wait_result(0, 32, 40'h2345, 1'b0, 1'b1, "d4_12345");
      @(negedge clk);
      launch(1, 32'd9999);
      wait_result(0, 32, 40'h9999, 1'b0, 1'b0, "d4_9999");
      @(negedge clk);
      launch(1, 32'd10000);
      wait_result(0, 32, 40'h0000, 1'b0, 1'b1, "d4_10000");

      // Signed 32-bit
      @(negedge clk);
      launch(2, 32'hFFFF_FF85);
      wait_result(0, 32, 40'h123, 1'b1, 1'b0, "s_m123");
      @(negedge clk);
      launch(2, 32'h8000_0000);
      wait_result(0, 32, 40'h21_4748_3648, 1'b1, 1'b0, "s_min");
      @(negedge clk);
      launch(2, 32'd5);
      wait_result(0, 32, 40'h5, 1'b0, 1'b0, "s_5");
      @(negedge clk);
      launch(2, 32'h7FFF_FFFF);
      wait_result(0, 32, 40'h21_4748_3647, 1'b0, 1'b0, "s_max");
      @(negedge clk);
      launch(2, 32'hFFFF_FFFF);
      wait_result(0, 32, 40'h1, 1'b1, 1'b0, "s_m1");

      // Signed 8-bit, 3 digits
      @(negedge clk);
      launch(3, 32'h80);
      wait_result(0, 8, 40'h128, 1'b1, 1'b0, "s8_min");
      @(negedge clk);
      launch(3, 32'h7F);
      wait_result(0, 8, 40'h127, 1'b0, 1'b0, "s8_max");
      @(negedge clk);
      launch(3, 32'h00);
      wait_result(0, 8, 40'h0, 1'b0, 1'b0, "s8_zero");

      // Unsigned 8-bit, 2 digits
      @(negedge clk);
      launch(4, 32'd255);
      wait_result(0, 8, 40'h55, 1'b0, 1'b1, "u8_255");
      @(negedge clk);
      launch(4, 32'd99);
      wait_result(0, 8, 40'h99, 1'b0, 1'b0, "u8_99");
      @(negedge clk);
      launch(4, 32'd100);
      wait_result(0, 8, 40'h00, 1'b0, 1'b1, "u8_100");

      // Unsigned 16-bit, 5 digits
      @(negedge clk);
      launch(5, 32'd65535);
      wait_result(0, 16, 40'h65535, 1'b0, 1'b0, "u16_max");
      @(negedge clk);
      launch(5, 32'd1000);
      wait_result(0, 16, 40'h1000, 1'b0, 1'b0, "u16_1000");

      // Reset mid-conversion: immediate clear, no valid, prior result lost
      @(negedge clk);
      launch(0, 32'd777);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_bcd", o_bcd, 40'h0);
      chk("mid_rst_busy", 40'(o_busy), 40'd0);
      chk("mid_rst_valid", 40'(o_valid), 40'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("no_valid_after_rst", 40'(o_valid), 40'd0);
      chk("no_busy_after_rst", 40'(o_busy), 40'd0);
      launch(0, 32'd12345);
      wait_result(0, 32, 40'h12345, 1'b0, 1'b0, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_convert_seq.md
Name: bcd_convert_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
- Replaces the combinational converter in the display path, where a 32-bit full unroll is too slow for the core clock.
- Adds a start/busy/valid handshake, a configurable digit count, optional signed (sign-magnitude) mode and an overflow flag.
- Feeds the seven-segment display driver from CPU counters and registers.

Parameters:
- BIN_W, 32: width of the binary input; must be >= 2.
- DIGITS, 10: number of BCD digits produced; output width is 4*DIGITS.
- SIGNED, 0: 1 = input is two's complement, converted as magnitude plus sign flag; 0 = unsigned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request a conversion; accepted only when busy=0.
- bin  input  BIN_W  binary value; sampled on the accepting edge only.
- busy  output  1  conversion in progress.
- valid  output  1  one-cycle pulse: bcd/neg/ovf updated this cycle.
- bcd  output  4*DIGITS  result, digit 0 in [3:0]; held until the next result.
- neg  output  1  result is negative (SIGNED=1 only, else constant 0).
- ovf  output  1  magnitude needed more than DIGITS digits.

Behaviour:
- Reset, asynchronous and immediate: state IDLE; busy=0, valid=0, bcd=0, neg=0, ovf=0; internal shift register, digit accumulator and counter cleared.
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1.
  - No separate DONE state; valid is a registered pulse.
- Accept (edge E0: state IDLE, start=1):
  - Load magnitude into the shift register.
  - With SIGNED=1 and bin[BIN_W-1]=1, magnitude = (~bin + 1) as unsigned BIN_W bits, so -2^(BIN_W-1) gives 2^(BIN_W-1); latch sign internally.
  - Clear digit accumulator and internal ovf; counter = BIN_W-1; go to SHIFT.
- SHIFT step (edges E1..E_BIN_W), per edge:
  - For every digit >= 5 add 3, all digits in parallel on pre-shift values.
  - Shift the {digits, shift register} chain left one bit; the MSB of the shift register enters digit 0 bit 0.
  - Bit 3 of the top digit is shifted out and ORed into the sticky internal ovf.
  - Decrement the counter.
- Completion, on edge E_BIN_W (the last shift): bcd <= final digits, neg <= latched sign, ovf <= sticky ovf, valid <= 1, busy <= 0, state -> IDLE.
- Latency: valid is high in the cycle after edge E_BIN_W, i.e. BIN_W cycles after acceptance.
- valid lasts exactly one cycle; bcd/neg/ovf hold until the next completion and do not change at acceptance.
- start while busy=1 is ignored (not queued); bin may change freely during conversion.
- Back-to-back: start asserted in the valid cycle (busy=0) is accepted on the next edge; throughput is one conversion per BIN_W+1 cycles.
- Overflow: bcd = magnitude mod 10^DIGITS, ovf=1. No overflow is possible when DIGITS >= ceil(BIN_W*log10(2)).
- Zero input yields bcd=0, neg=0, ovf=0. Negative zero cannot occur.
- Reset asserted mid-conversion aborts it; no valid pulse; the prior bcd is lost (cleared to 0).
- start held high continuously converts repeatedly, re-sampling bin at each acceptance.

Test Plan:
- Default params, bin=0, start 1 cycle -> busy high 32 cycles; valid pulse after 32 cycles; bcd=0, ovf=0.
- bin=32'hFFFFFFFF (4294967295) -> bcd=40'h4294967295, ovf=0. Then bin=32'd99 with start pulsed during busy -> ignored, result unchanged. Then start in the valid cycle -> next result 40'h0000000099 after 32 more cycles.
- DIGITS=4, bin=12345 -> bcd=16'h2345, ovf=1. Then bin=9999 -> bcd=16'h9999, ovf=0.
- SIGNED=1: bin=32'hFFFFFF85 -> neg=1, bcd=...123. bin=32'h80000000 -> neg=1, bcd=40'h2147483648. bin=32'd5 -> neg=0, bcd=5.
- Reset asserted 10 cycles into a conversion -> all outputs 0 immediately, no valid pulse; a new start after release converts correctly.
- Random regression, 1000 values across BIN_W=8/16/32 and both SIGNED settings -> bcd/neg/ovf match the reference model; valid exactly BIN_W cycles after each accepted start.
